// File: rtl/cork_pkg.sv
// Shared definitions for the cork reservoir stock manager.
// Holds the FSM state encodings and the default reservoir sizing.
// Optional build macro used by the slice: CORK_BATCH_EN (batch refill adds).
package cork_pkg;

  // Default reservoir sizing
  localparam int unsigned CAP_DEF    = 15;
  localparam int unsigned LOW_TH_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 4;

  // FSM state encodings (also exported on state_o)
  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_OK    = 2'b00;
  localparam logic [ST_W-1:0] ST_LOW   = 2'b01;
  localparam logic [ST_W-1:0] ST_FULL  = 2'b10;
  localparam logic [ST_W-1:0] ST_FAULT = 2'b11;

endpackage

// File: rtl/edge_rise_det.sv
// One-bit rising-edge detector.
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous, active-high; clears the history bit
//   i_sig    - level input
//   o_rise_c - combinational pulse: i_sig high now, low on the previous clock
module edge_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise_c
);

  logic r_prev;

  // History of the input level, one clock behind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise_c = i_sig & ~r_prev;

endmodule

// File: rtl/cork_stock_manager.sv
// Cork reservoir stock manager: counts corks added/dispensed, raises a refill
// request with hysteresis, and latches a sticky fault on under/overflow.
// Build macro: CORK_BATCH_EN - each add event adds LOW_TH corks (saturating)
//              instead of a single cork.
// Ports:
//   clk, reset  - clock (rising edge), asynchronous active-high reset
//   disp_in     - dispensed level; each rising edge removes one cork
//   add_in      - added level; each rising edge adds corks
//   clr_err     - operator acknowledge, releases the FAULT state
//   stock       - current cork count
//   cork_avail  - stock != 0
//   refill_req  - request more corks
//   full        - stock == CAP
//   err         - sticky underflow/overflow fault
//   state_o     - current FSM state (OK/LOW/FULL/FAULT)
module cork_stock_manager
  import cork_pkg::*;
#(
  parameter int unsigned CAP    = CAP_DEF,
  parameter int unsigned LOW_TH = LOW_TH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             disp_in,
  input  logic             add_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] stock,
  output logic             cork_avail,
  output logic             refill_req,
  output logic             full,
  output logic             err,
  output logic [ST_W-1:0]  state_o
);

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] LOW_C = CNT_W'(LOW_TH);

  logic [CNT_W-1:0] r_stock;
  logic [ST_W-1:0]  r_state;
  logic             r_err;
  logic             r_full;
  logic             r_avail;
  logic             r_refill;

  logic             w_disp_rise;
  logic             w_add_rise;
  logic [CNT_W-1:0] w_after_disp;
  logic [CNT_W-1:0] w_stock_nxt;
  logic             w_underflow;
  logic             w_overflow;
  logic             w_err_set;
  logic [ST_W-1:0]  w_state_nxt;
  logic             w_err_nxt;
  logic             w_full_nxt;
  logic             w_avail_nxt;
  logic             w_refill_nxt;
`ifdef CORK_BATCH_EN
  logic [CNT_W:0]   w_sum;
`endif

  // Event detection on the dispenser levels
  edge_rise_det u_disp_det (
    .clk      (clk),
    .reset    (reset),
    .i_sig    (disp_in),
    .o_rise_c (w_disp_rise)
  );

  edge_rise_det u_add_det (
    .clk      (clk),
    .reset    (reset),
    .i_sig    (add_in),
    .o_rise_c (w_add_rise)
  );

  // Next stock: the dispense is applied first, then the add, so an add in the
  // same cycle as an underflowing dispense still counts.
  always_comb begin
    w_after_disp = r_stock;
    w_underflow  = 1'b0;
    w_overflow   = 1'b0;
`ifdef CORK_BATCH_EN
    w_sum        = '0;
`endif
    if (w_disp_rise) begin
      if (r_stock == '0) begin
        w_underflow = 1'b1;
      end else begin
        w_after_disp = r_stock - CNT_W'(1);
      end
    end
    w_stock_nxt = w_after_disp;
    if (w_add_rise) begin
      if (w_after_disp == CAP_C) begin
        w_overflow = 1'b1;
      end
`ifdef CORK_BATCH_EN
      w_sum = {1'b0, w_after_disp} + (CNT_W+1)'(LOW_TH);
      if (w_sum >= (CNT_W+1)'(CAP)) begin
        w_stock_nxt = CAP_C;
      end else begin
        w_stock_nxt = w_sum[CNT_W-1:0];
      end
`else
      if (!w_overflow) begin
        w_stock_nxt = w_after_disp + CNT_W'(1);
      end
`endif
    end
  end

  assign w_err_set = w_underflow | w_overflow;

  // Next state and next registered outputs, all judged on the next stock
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      ST_OK: begin
        if (w_stock_nxt < LOW_C) begin
          w_state_nxt = ST_LOW;
        end else if (w_stock_nxt == CAP_C) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_LOW: begin
        // Hysteresis: a low reservoir is refilled all the way up
        if (w_stock_nxt == CAP_C) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_stock_nxt < LOW_C) begin
          w_state_nxt = ST_LOW;
        end else if (w_stock_nxt < CAP_C) begin
          w_state_nxt = ST_OK;
        end
      end
      ST_FAULT: begin
        if (clr_err) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = (w_stock_nxt < LOW_C) ? ST_LOW : ST_OK;
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
      end
    endcase
    // A new fault wins over any transition, including an acknowledge
    if (w_err_set) begin
      w_state_nxt = ST_FAULT;
      w_err_nxt   = 1'b1;
    end
    w_full_nxt   = (w_stock_nxt == CAP_C);
    w_avail_nxt  = (w_stock_nxt != '0);
    w_refill_nxt = (w_state_nxt == ST_LOW) ||
                   ((w_state_nxt == ST_FAULT) && (w_stock_nxt < LOW_C));
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stock  <= '0;
      r_state  <= ST_LOW;
      r_err    <= 1'b0;
      r_full   <= 1'b0;
      r_avail  <= 1'b0;
      r_refill <= 1'b1;
    end else begin
      r_stock  <= w_stock_nxt;
      r_state  <= w_state_nxt;
      r_err    <= w_err_nxt;
      r_full   <= w_full_nxt;
      r_avail  <= w_avail_nxt;
      r_refill <= w_refill_nxt;
    end
  end

  assign stock      = r_stock;
  assign state_o    = r_state;
  assign err        = r_err;
  assign full       = r_full;
  assign cork_avail = r_avail;
  assign refill_req = r_refill;

endmodule

// File: tb/tb_cork_stock_manager.sv
// Scoreboard bench for cork_stock_manager: directed scenarios followed by
// randomized add/dispense/clear/reset traffic, checked against a
// behavioural reservoir model.
module tb_cork_stock_manager;

  localparam int CAP    = 15;
  localparam int LOW_TH = 5;
  localparam int S_OK = 0, S_LOW = 1, S_FULL = 2, S_FAULT = 3;
`ifdef CORK_BATCH_EN
  localparam int ADD_INC = LOW_TH;
`else
  localparam int ADD_INC = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       disp_in = 1'b0;
  logic       add_in = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] stock;
  logic       cork_avail;
  logic       refill_req;
  logic       full;
  logic       err;
  logic [1:0] state_o;

  cork_stock_manager dut (
    .clk        (clk),
    .reset      (reset),
    .disp_in    (disp_in),
    .add_in     (add_in),
    .clr_err    (clr_err),
    .stock      (stock),
    .cork_avail (cork_avail),
    .refill_req (refill_req),
    .full       (full),
    .err        (err),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stock;
    int st;
    int err;
    int full;
    int avail;
    int refill;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model of the reservoir
  int m_stock = 0;
  int m_st    = S_LOW;
  int m_err   = 0;
  bit m_pd    = 1'b0;
  bit m_pa    = 1'b0;

  task automatic model_step(input bit d, input bit a, input bit c, input bit r);
    exp_t e;
    bit   rd, ra, bad;
    int   s;
    if (r) begin
      m_stock = 0; m_st = S_LOW; m_err = 0; m_pd = 1'b0; m_pa = 1'b0;
    end else begin
      rd = d && !m_pd;
      ra = a && !m_pa;
      m_pd = d;
      m_pa = a;
      bad = 1'b0;
      s = m_stock;
      if (rd) begin
        if (s == 0) bad = 1'b1;
        else s = s - 1;
      end
      if (ra) begin
        if (s == CAP) bad = 1'b1;
        s = (s + ADD_INC > CAP) ? CAP : s + ADD_INC;
      end
      m_stock = s;
      if (bad) begin
        m_st = S_FAULT; m_err = 1;
      end else begin
        case (m_st)
          S_OK:    if (s < LOW_TH) m_st = S_LOW; else if (s == CAP) m_st = S_FULL;
          S_LOW:   if (s == CAP) m_st = S_FULL;
          S_FULL:  if (s < LOW_TH) m_st = S_LOW; else if (s < CAP) m_st = S_OK;
          default: if (c) begin m_err = 0; m_st = (s < LOW_TH) ? S_LOW : S_OK; end
        endcase
      end
    end
    e.stock  = m_stock;
    e.st     = m_st;
    e.err    = m_err;
    e.full   = (m_stock == CAP) ? 1 : 0;
    e.avail  = (m_stock != 0) ? 1 : 0;
    e.refill = ((m_st == S_LOW) || (m_st == S_FAULT && m_stock < LOW_TH)) ? 1 : 0;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs away from the active edge and queue the result
  task automatic cyc(input bit d, input bit a, input bit c, input bit r);
    @(negedge clk);
    disp_in = d;
    add_in  = a;
    clr_err = c;
    reset   = r;
    model_step(d, a, c, r);
  endtask

  task automatic chk(input string name, input int act, input int req, input int idx);
    if (act != req) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, req);
    end
  endtask

  // Monitor: one registered result per clock after each queued stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        chk("stock",      int'(stock),      e.stock,  n_vec);
        chk("state",      int'(state_o),    e.st,     n_vec);
        chk("err",        int'(err),        e.err,    n_vec);
        chk("full",       int'(full),       e.full,   n_vec);
        chk("cork_avail", int'(cork_avail), e.avail,  n_vec);
        chk("refill_req", int'(refill_req), e.refill, n_vec);
      end
    end
  end

  initial begin
    int pa, pd;
    // Reset, then fill from empty to capacity
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    // Drain to the low threshold and on to empty
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    // Underflow, hold the fault, then acknowledge
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    // Underflow with simultaneous add
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    // Up to 7, then simultaneous add and dispense
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    // Held add level counts once
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    // Fill to capacity and overflow, then acknowledge
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 1, 0);
    // Reset mid-operation coinciding with a dispense rise
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // Randomized traffic, alternating add-heavy and dispense-heavy phases
    for (int i = 0; i < 3000; i++) begin
      pa = ((i / 300) % 2 == 0) ? 70 : 30;
      pd = 100 - pa;
      cyc(($urandom_range(0, 99) < pd), ($urandom_range(0, 99) < pa),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 299) == 0));
    end
    cyc(0, 0, 0, 0);
    // Let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
